// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input_conditioner block.
package input_cond_pkg;

  localparam int CNT_W           = 8;
  localparam int DEB_CYCLES_1MS  = 27000;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Smallest debounce counter width that can hold DEB_CYCLES-1.
  function automatic int deb_w_for(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One conditioned channel: synchronizer, debouncer, edge pulses, sticky flags, counters.
// glitch_cnt exists only when INPUT_COND_GLITCH_CNT_EN is defined.
module input_cond_ch
  import input_cond_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 27000,
  parameter int   DEB_W       = 16,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk27,
  input  logic             reset,
  input  logic             in_async,
  input  logic             deb_en,
  input  logic             clr,
  output logic             level,
  output logic             rise_evt,
  output logic             fall_evt,
  output logic             rise_sticky,
  output logic             fall_sticky,
  output logic [CNT_W-1:0] rise_cnt
`ifdef INPUT_COND_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  localparam logic [DEB_W-1:0] DC_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] DC_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0] DC_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic                   level_r;
  logic                   level_nxt_s;
  logic [DEB_W-1:0]       dc_r;
  logic [DEB_W-1:0]       dc_nxt_s;
  logic                   rise_r;
  logic                   fall_r;
  logic                   rise_nxt_s;
  logic                   fall_nxt_s;
  logic                   rise_sticky_r;
  logic                   fall_sticky_r;
  logic [CNT_W-1:0]       rise_cnt_r;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Debounce decision: bypass follows s, otherwise a mismatch must persist DEB_CYCLES cycles.
  always_comb begin
    level_nxt_s = level_r;
    dc_nxt_s    = DC_ZERO;
    if (!deb_en) begin
      level_nxt_s = s_s;
      dc_nxt_s    = DC_ZERO;
    end else if (s_s == level_r) begin
      dc_nxt_s = DC_ZERO;
    end else if (dc_r == DC_LAST) begin
      level_nxt_s = s_s;
      dc_nxt_s    = DC_ZERO;
    end else begin
      dc_nxt_s = dc_r + DC_ONE;
    end
    rise_nxt_s = level_nxt_s & ~level_r;
    fall_nxt_s = ~level_nxt_s & level_r;
  end

  // Main channel state; sticky flags and rise_cnt follow the registered pulses so set beats clear.
  always_ff @(posedge clk27) begin
    if (reset) begin
      sync_r        <= {SYNC_STAGES{RESET_VAL}};
      level_r       <= RESET_VAL;
      dc_r          <= DC_ZERO;
      rise_r        <= 1'b0;
      fall_r        <= 1'b0;
      rise_sticky_r <= 1'b0;
      fall_sticky_r <= 1'b0;
      rise_cnt_r    <= CNT_ZERO;
    end else begin
      sync_r        <= {sync_r[SYNC_STAGES-2:0], in_async};
      level_r       <= level_nxt_s;
      dc_r          <= dc_nxt_s;
      rise_r        <= rise_nxt_s;
      fall_r        <= fall_nxt_s;
      rise_sticky_r <= rise_r | (rise_sticky_r & ~clr);
      fall_sticky_r <= fall_r | (fall_sticky_r & ~clr);
      if (rise_r) begin
        rise_cnt_r <= rise_cnt_r + CNT_ONE;
      end else begin
        rise_cnt_r <= rise_cnt_r;
      end
    end
  end

  assign level       = level_r;
  assign rise_evt    = rise_r;
  assign fall_evt    = fall_r;
  assign rise_sticky = rise_sticky_r;
  assign fall_sticky = fall_sticky_r;
  assign rise_cnt    = rise_cnt_r;

`ifdef INPUT_COND_GLITCH_CNT_EN
  logic             glitch_hit_s;
  logic [CNT_W-1:0] glitch_r;
  logic [CNT_W-1:0] glitch_nxt_s;

  assign glitch_hit_s = (dc_r != DC_ZERO) && (s_s == level_r);

  // Saturating count of mismatch runs that collapsed before acceptance.
  always_comb begin
    glitch_nxt_s = glitch_r;
    if (clr) begin
      glitch_nxt_s = glitch_hit_s ? CNT_ONE : CNT_ZERO;
    end else if (glitch_hit_s && (glitch_r != CNT_MAX)) begin
      glitch_nxt_s = glitch_r + CNT_ONE;
    end else begin
      glitch_nxt_s = glitch_r;
    end
  end

  // Glitch counter register.
  always_ff @(posedge clk27) begin
    if (reset) begin
      glitch_r <= CNT_ZERO;
    end else begin
      glitch_r <= glitch_nxt_s;
    end
  end

  assign glitch_cnt = glitch_r;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel conditioner for asynchronous board inputs in the clk27 domain.
// Define INPUT_COND_GLITCH_CNT_EN to add the per-channel glitch_cnt output.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                DEB_CYCLES  = 27000,
  parameter int                DEB_W       = 16,
  parameter logic [NUM_CH-1:0] RESET_VAL   = {NUM_CH{1'b0}}
) (
  input  logic                    clk27,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in_async,
  input  logic [NUM_CH-1:0]       deb_en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       clr_mask,
  output logic [NUM_CH-1:0]       level_out,
  output logic [NUM_CH-1:0]       rise_evt,
  output logic [NUM_CH-1:0]       fall_evt,
  output logic [NUM_CH-1:0]       rise_sticky,
  output logic [NUM_CH-1:0]       fall_sticky,
  output logic [CNT_W*NUM_CH-1:0] rise_cnt
`ifdef INPUT_COND_GLITCH_CNT_EN
  ,
  output logic [CNT_W*NUM_CH-1:0] glitch_cnt
`endif
);

  logic [NUM_CH-1:0] clr_ch_s;

  assign clr_ch_s = {NUM_CH{clr}} & clr_mask;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_cond_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES),
      .DEB_W       (DEB_W),
      .RESET_VAL   (RESET_VAL[i])
    ) u_ch (
      .clk27       (clk27),
      .reset       (reset),
      .in_async    (in_async[i]),
      .deb_en      (deb_en[i]),
      .clr         (clr_ch_s[i]),
      .level       (level_out[i]),
      .rise_evt    (rise_evt[i]),
      .fall_evt    (fall_evt[i]),
      .rise_sticky (rise_sticky[i]),
      .fall_sticky (fall_sticky[i]),
      .rise_cnt    (rise_cnt[CNT_W*i +: CNT_W])
`ifdef INPUT_COND_GLITCH_CNT_EN
      ,
      .glitch_cnt  (glitch_cnt[CNT_W*i +: CNT_W])
`endif
    );
  end

endmodule
